// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin front end for a shared integer ALU with iterative mul/div.
// Each accepted op runs to a registered, tagged response before the next grant.
module alu_op_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [3:0]         req0_op_i,
    input  logic [WIDTH-1:0]   req0_a_i,
    input  logic [WIDTH-1:0]   req0_b_i,
    input  logic               req0_cin_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [3:0]         req1_op_i,
    input  logic [WIDTH-1:0]   req1_a_i,
    input  logic [WIDTH-1:0]   req1_b_i,
    input  logic               req1_cin_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [2*WIDTH-1:0] rsp_result_o,
    output logic               rsp_carry_o,
    output logic               rsp_zero_o,
    output logic               rsp_err_o,
    output logic               busy_o
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_ADD = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opb_q, opb_d;
    logic             cin_q, cin_d, id_q, id_d;
    logic [W2-1:0]    acc_q, acc_d, opa_q, opa_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic             rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
    logic [W2-1:0]    rsp_result_q, rsp_result_d;

    logic             grant0, grant1, accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        grant0  = (state_q == IDLE) && req0_valid_i && (!req1_valid_i || last_grant_q);
        grant1  = (state_q == IDLE) && req1_valid_i && (!req0_valid_i || !last_grant_q);
        accept  = grant0 || grant1;
        sel_op  = grant1 ? req1_op_i  : req0_op_i;
        sel_a   = grant1 ? req1_a_i   : req0_a_i;
        sel_b   = grant1 ? req1_b_i   : req0_b_i;
        sel_cin = grant1 ? req1_cin_i : req0_cin_i;
    end

    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] exec_lo;
    logic             exec_carry;
    always_comb begin
        sum_w      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_w     = {1'b0, a_q} - {1'b0, b_q};
        exec_lo    = '0;
        exec_carry = 1'b0;
        case (op_q)
            4'b0000: exec_lo = a_q & b_q;
            4'b0001: exec_lo = ~(a_q & b_q);
            4'b0010: exec_lo = a_q | b_q;
            4'b0011: exec_lo = ~(a_q | b_q);
            4'b0100: exec_lo = a_q ^ b_q;
            4'b0101: exec_lo = ~(a_q ^ b_q);
            4'b0110: exec_lo = ~a_q;
            OP_ADD:  begin exec_lo = sum_w[WIDTH-1:0];  exec_carry = sum_w[WIDTH];  end
            OP_SUB:  begin exec_lo = diff_w[WIDTH-1:0]; exec_carry = diff_w[WIDTH]; end
            default: exec_lo = '0;
        endcase
    end

    // One shift-add or restoring-division step; acc holds product or remainder,
    // opa holds the shifting multiplicand or the quotient being built.
    logic [W2-1:0]    mul_acc;
    logic [WIDTH:0]   rem_sh, trial, rem_n;
    logic [WIDTH-1:0] quo_n;
    always_comb begin
        mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh  = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, b_q};
        rem_n   = trial[WIDTH] ? rem_sh : trial;
        quo_n   = {opa_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        id_d         = id_q;
        acc_d        = acc_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant1;
                    id_d         = grant1;
                    op_d         = sel_op;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    cin_d        = sel_cin;
                    acc_d        = '0;
                    opa_d        = {{WIDTH{1'b0}}, sel_a};
                    opb_d        = sel_b;
                    cnt_d        = '0;
                    if (sel_op > OP_DIV) begin
                        state_d      = RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_id_d     = grant1;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp_zero_d   = 1'b1;
                        rsp_err_d    = 1'b1;
                    end else if (sel_op == OP_MUL || sel_op == OP_DIV) begin
                        state_d = ITER;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = {{WIDTH{1'b0}}, exec_lo};
                rsp_carry_d  = exec_carry;
                rsp_zero_d   = (exec_lo == '0);
                rsp_err_d    = 1'b0;
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    acc_d = {{(W2-WIDTH-1){1'b0}}, rem_n};
                    opa_d = {{WIDTH{1'b0}}, quo_n};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_carry_d = 1'b0;
                    if (op_q == OP_MUL) begin
                        rsp_result_d = mul_acc;
                        rsp_err_d    = 1'b0;
                    end else begin
                        rsp_result_d = {rem_n[WIDTH-1:0], quo_n};
                        rsp_err_d    = (b_q == '0);
                    end
                    rsp_zero_d = (rsp_result_d == '0);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_carry_o  = rsp_carry_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random two-requester traffic
// checked against an arithmetic reference model and a round-robin grant model.
module tb_alu_op_scheduler;
    localparam int WIDTH = 4;

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic             req0_ready_o, req1_ready_o;
    logic [3:0]       req0_op_i = '0, req1_op_i = '0;
    logic [WIDTH-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic             req0_cin_i = 1'b0, req1_cin_i = 1'b0;
    logic             rsp_valid_o, rsp_ready_i = 1'b1, rsp_id_o;
    logic [7:0]       rsp_result_o;
    logic             rsp_carry_o, rsp_zero_o, rsp_err_o, busy_o;

    int vectors = 0;
    int miscompares = 0;
    int model_last = 1;

    alu_op_scheduler #(.WIDTH(WIDTH)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_cin_i(req0_cin_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_cin_i(req1_cin_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_carry_o(rsp_carry_o), .rsp_zero_o(rsp_zero_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    // Reference model: plain integer arithmetic on 4-bit operands.
    function automatic void model(input int op, input int a, input int b, input int cin,
                                  output int r, output int c, output int z, output int e,
                                  output int lat);
        r = 0; c = 0; e = 0; lat = 2;
        case (op)
            0: r = a & b;
            1: r = ~(a & b) & 15;
            2: r = a | b;
            3: r = ~(a | b) & 15;
            4: r = a ^ b;
            5: r = ~(a ^ b) & 15;
            6: r = ~a & 15;
            7: begin r = (a + b + cin) % 16; c = ((a + b + cin) >= 16) ? 1 : 0; end
            8: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            9: begin r = a * b; lat = WIDTH + 1; end
            10: begin
                lat = WIDTH + 1;
                if (b == 0) begin r = a * 16 + 15; e = 1; end
                else r = (a % b) * 16 + a / b;
            end
            default: begin r = 0; e = 1; lat = 1; end
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    task automatic set_req(input int who, input int op, input int a, input int b, input int cin);
        if (who == 0) begin
            req0_valid_i = 1'b1; req0_op_i = 4'(op); req0_a_i = 4'(a); req0_b_i = 4'(b); req0_cin_i = 1'(cin);
        end else begin
            req1_valid_i = 1'b1; req1_op_i = 4'(op); req1_a_i = 4'(a); req1_b_i = 4'(b); req1_cin_i = 1'(cin);
        end
    endtask

    task automatic drop_req(input int who);
        if (who == 0) req0_valid_i = 1'b0;
        else          req1_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock_i);
        reset_i = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (2) @(posedge clock_i);
        #1 reset_i = 1'b0;
        model_last = 1;
    endtask

    // Waits for a grant, then for the response; latency counts the accepting edge as 1.
    task automatic serve(output int ok, output int win, output int both_rdy, output int lat,
                         output logic [7:0] res, output logic c, output logic z,
                         output logic e, output logic id, output logic vafter);
        int n;
        ok = 1; win = -1; both_rdy = 0; lat = 0;
        res = '0; c = 0; z = 0; e = 0; id = 0; vafter = 0;
        #1;
        n = 0;
        while (!(req0_ready_o || req1_ready_o) && n < 40) begin @(negedge clock_i); n++; end
        if (!(req0_ready_o || req1_ready_o)) begin ok = 0; return; end
        both_rdy = (req0_ready_o && req1_ready_o) ? 1 : 0;
        win = req1_ready_o ? 1 : 0;
        @(posedge clock_i); #1; drop_req(win); lat = 1;
        @(negedge clock_i);
        n = 0;
        while (!rsp_valid_o && n < 40) begin @(negedge clock_i); lat++; n++; end
        if (!rsp_valid_o) begin ok = 0; return; end
        res = rsp_result_o; c = rsp_carry_o; z = rsp_zero_o; e = rsp_err_o; id = rsp_id_o;
        @(posedge clock_i); #1;
        vafter = rsp_valid_o;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock_i);
        vectors++;
        if ({busy_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_err_o,
             req0_ready_o, req1_ready_o} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b valid=%b res=%h expected all zero",
                     busy_o, rsp_valid_o, rsp_result_o);
        end
        $display("reset: busy=%b rsp_valid=%b", busy_o, rsp_valid_o);
    endtask

    task automatic test_add();
        int ok, win, both, lat; logic [7:0] res; logic c, z, e, id, va;
        do_reset();
        set_req(0, 7, 3, 1, 0);
        serve(ok, win, both, lat, res, c, z, e, id, va);
        model_last = 0;
        vectors++;
        if (ok !== 1 || lat !== 2) begin
            miscompares++;
            $display("FAIL add_latency: got ok=%0d lat=%0d expected lat=2", ok, lat);
        end
        vectors++;
        if ({id, res, c, z, e} !== {1'b0, 8'h04, 3'b000}) begin
            miscompares++;
            $display("FAIL add_result: got id=%b res=%h c=%b z=%b e=%b expected id=0 res=04 c=0 z=0 e=0",
                     id, res, c, z, e);
        end
        $display("add 3+1: id=%b res=%h lat=%0d", id, res, lat);
    endtask

    task automatic test_tie();
        int ok, win, both, lat, exp_win; logic [7:0] res; logic c, z, e, id, va;
        logic [7:0] exp_res [3];
        exp_res[0] = 8'h00; exp_res[1] = 8'h0F; exp_res[2] = 8'h0B;
        do_reset();
        set_req(0, 0, 10, 5, 0);
        set_req(1, 2, 10, 5, 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                set_req(0, 4, 12, 7, 0);
                set_req(1, 3, 12, 7, 0);
            end
            exp_win = (req0_valid_i && req1_valid_i) ? (model_last == 1 ? 0 : 1)
                                                     : (req1_valid_i ? 1 : 0);
            serve(ok, win, both, lat, res, c, z, e, id, va);
            model_last = exp_win;
            vectors++;
            if (ok !== 1 || both !== 0 || win !== exp_win || id !== 1'(exp_win)) begin
                miscompares++;
                $display("FAIL tie_grant[%0d]: got ok=%0d both=%0d win=%0d id=%b expected win=%0d",
                         k, ok, both, win, id, exp_win);
            end
            vectors++;
            if (res !== exp_res[k] || z !== (exp_res[k] == 8'h00)) begin
                miscompares++;
                $display("FAIL tie_result[%0d]: got res=%h z=%b expected res=%h", k, res, z, exp_res[k]);
            end
            $display("tie round %0d: win=%0d res=%h", k, win, res);
        end
        drop_req(1);
    endtask

    task automatic test_directed_ops();
        int ok, win, both, lat; logic [7:0] res; logic c, z, e, id, va;
        int         ops  [7] = '{9, 9, 7, 10, 10, 8, 12};
        int         aa   [7] = '{3, 15, 15, 4, 7, 2, 5};
        int         bb   [7] = '{2, 15, 1, 2, 0, 4, 5};
        int         cc   [7] = '{0, 0, 1, 0, 0, 0, 0};
        logic [7:0] xres [7] = '{8'h06, 8'hE1, 8'h01, 8'h02, 8'h7F, 8'h0E, 8'h00};
        logic       xc   [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic       xe   [7] = '{0, 0, 0, 0, 1, 0, 1};
        int         xlat [7] = '{5, 5, 2, 5, 5, 2, 1};
        for (int k = 0; k < 7; k++) begin
            set_req(0, ops[k], aa[k], bb[k], cc[k]);
            serve(ok, win, both, lat, res, c, z, e, id, va);
            model_last = 0;
            vectors++;
            if (ok !== 1 || lat !== xlat[k]) begin
                miscompares++;
                $display("FAIL op_latency[%0d]: got ok=%0d lat=%0d expected lat=%0d", k, ok, lat, xlat[k]);
            end
            vectors++;
            if ({res, c, z, e, id} !== {xres[k], xc[k], xres[k] == 8'h00, xe[k], 1'b0}) begin
                miscompares++;
                $display("FAIL op_result[%0d]: got res=%h c=%b z=%b e=%b id=%b expected res=%h c=%b e=%b",
                         k, res, c, z, e, id, xres[k], xc[k], xe[k]);
            end
            $display("op %0d a=%0d b=%0d: res=%h c=%b e=%b lat=%0d", ops[k], aa[k], bb[k], res, c, e, lat);
        end
    endtask

    task automatic test_backpressure();
        int ok, win, both, lat, n, er, ec, ez, ee, el;
        logic [7:0] res, r0; logic c, z, e, id, va, c0, z0, e0, id0;
        rsp_ready_i = 1'b0;
        set_req(0, 7, 5, 6, 0);
        #1;
        n = 0;
        while (!req0_ready_o && n < 40) begin @(negedge clock_i); n++; end
        vectors++;
        if (!req0_ready_o) begin
            miscompares++;
            $display("FAIL bp_grant: got ready0=0 expected ready0=1");
        end
        @(posedge clock_i); #1;
        drop_req(0);
        model_last = 0;
        set_req(1, 4, 12, 10, 0);
        @(negedge clock_i);
        n = 0;
        while (!rsp_valid_o && n < 40) begin @(negedge clock_i); n++; end
        r0 = rsp_result_o; c0 = rsp_carry_o; z0 = rsp_zero_o; e0 = rsp_err_o; id0 = rsp_id_o;
        model(7, 5, 6, 0, er, ec, ez, ee, el);
        vectors++;
        if (rsp_valid_o !== 1'b1 || {id0, r0, c0, z0, e0} !== {1'b0, 8'(er), 1'(ec), 1'(ez), 1'(ee)}) begin
            miscompares++;
            $display("FAIL bp_result: got valid=%b res=%h c=%b expected res=%h c=%0d",
                     rsp_valid_o, r0, c0, 8'(er), ec);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_i);
            vectors++;
            if (!rsp_valid_o || req0_ready_o || req1_ready_o ||
                {rsp_id_o, rsp_result_o, rsp_carry_o, rsp_zero_o, rsp_err_o} !== {id0, r0, c0, z0, e0}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdy=%b%b res=%h expected valid=1 rdy=00 res=%h",
                         k, rsp_valid_o, req0_ready_o, req1_ready_o, rsp_result_o, r0);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clock_i); #1;
        vectors++;
        if (rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got rsp_valid=%b expected 0", rsp_valid_o);
        end
        $display("backpressure: held res=%h for 3 cycles", r0);
        serve(ok, win, both, lat, res, c, z, e, id, va);
        model_last = 1;
        vectors++;
        if (ok !== 1 || win !== 1 || res !== 8'h06) begin
            miscompares++;
            $display("FAIL bp_waiting_req1: got ok=%0d win=%0d res=%h expected win=1 res=06", ok, win, res);
        end
        set_req(0, 12, 9, 3, 1);
        serve(ok, win, both, lat, res, c, z, e, id, va);
        model_last = 0;
        vectors++;
        if (ok !== 1 || lat !== 1 || {res, c, z, e} !== {8'h00, 3'b011}) begin
            miscompares++;
            $display("FAIL illegal_op: got lat=%0d res=%h c=%b z=%b e=%b expected lat=1 res=00 z=1 e=1",
                     lat, res, c, z, e);
        end
        $display("illegal op 1100: lat=%0d err=%b", lat, e);
    endtask

    task automatic test_reset_mid();
        int ok, win, both, lat, seen; logic [7:0] res; logic c, z, e, id, va;
        set_req(0, 9, 15, 15, 0);
        #1;
        @(posedge clock_i); #1;
        drop_req(0);
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        vectors++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b rsp_valid=%b expected 0 0", busy_o, rsp_valid_o);
        end
        reset_i = 1'b0;
        model_last = 1;
        seen = 0;
        repeat (8) begin @(negedge clock_i); if (rsp_valid_o) seen = 1; end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_drop: got a response after reset expected none");
        end
        @(posedge clock_i); #1;
        set_req(1, 6, 10, 0, 0);
        serve(ok, win, both, lat, res, c, z, e, id, va);
        model_last = 1;
        vectors++;
        if (ok !== 1 || {id, res, c, z, e} !== {1'b1, 8'h05, 3'b000} || lat !== 2) begin
            miscompares++;
            $display("FAIL post_reset_not: got id=%b res=%h lat=%0d expected id=1 res=05 lat=2", id, res, lat);
        end
        $display("reset mid-MUL: NOT 1010 -> %h", res);
    endtask

    task automatic test_back_to_back();
        int ok, win, both, lat, exp_win, er, ec, ez, ee, el;
        logic [7:0] res; logic c, z, e, id, va;
        int pop [2], pa [2], pb [2], pc [2];
        bit pend [2];
        pend[0] = 0; pend[1] = 0;
        for (int k = 0; k < 60; k++) begin
            for (int w = 0; w < 2; w++) begin
                if (!pend[w] && ($urandom_range(0, 1) == 1 || (w == 1 && !pend[0]))) begin
                    pend[w] = 1;
                    pop[w] = $urandom_range(0, 12); pa[w] = $urandom_range(0, 15);
                    pb[w] = $urandom_range(0, 15);  pc[w] = $urandom_range(0, 1);
                    set_req(w, pop[w], pa[w], pb[w], pc[w]);
                end
            end
            exp_win = (pend[0] && pend[1]) ? (model_last == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
            model(pop[exp_win], pa[exp_win], pb[exp_win], pc[exp_win], er, ec, ez, ee, el);
            serve(ok, win, both, lat, res, c, z, e, id, va);
            model_last = exp_win;
            pend[exp_win] = 0;
            vectors++;
            if (ok !== 1 || both !== 0 || win !== exp_win || lat !== el || va !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_flow[%0d]: got ok=%0d both=%0d win=%0d lat=%0d va=%b expected win=%0d lat=%0d",
                         k, ok, both, win, lat, va, exp_win, el);
            end
            vectors++;
            if ({res, c, z, e, id} !== {8'(er), 1'(ec), 1'(ez), 1'(ee), 1'(exp_win)}) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: got res=%h c=%b z=%b e=%b id=%b expected res=%h c=%0d z=%0d e=%0d id=%0d",
                         k, res, c, z, e, id, 8'(er), ec, ez, ee, exp_win);
            end
            $display("b2b %0d: req%0d op=%0d a=%0d b=%0d -> res=%h lat=%0d",
                     k, exp_win, pop[exp_win], pa[exp_win], pb[exp_win], res, lat);
        end
        drop_req(0);
        drop_req(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_directed_ops();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
